mole_field_ctrl: RTL

Parametrised whack-a-mole playfield engine and successor to the fixed 5-hole generator, match and score datapath. Handles N independent holes, each with its own lifetime and cooldown timers, and spawns moles from an LFSR. It classifies each whack as a hit, a miss or an escape and keeps saturating hit, miss and escape counters. It sits under the game FSM, which drives clear/enable, and above the 7-segment and LED display logic.

---
 rtl/mole_pkg.sv | 45 ++++
 rtl/mole_hole.sv | 70 +++++++
 rtl/mole_field_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole playfield engine.
// Hole states, LFSR taps, default parameters and saturating arithmetic.
package mole_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    UP    = 2'd1,
    COOL  = 2'd2
  } hole_state_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int          DEF_N_HOLES     = 5;
  localparam int          DEF_TICK_CYCLES = 50000000;
  localparam int          DEF_UP_TICKS    = 3;
  localparam int          DEF_COOL_TICKS  = 1;
  localparam int          DEF_SPAWN_TICKS = 1;
  localparam int          DEF_SCORE_W     = 8;
  localparam logic [15:0] DEF_LFSR_SEED   = 16'hACE1;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] n,
    input logic [31:0] maxv
  );
    if (maxv - v < n) return maxv;
    return v + n;
  endfunction

  function automatic logic [31:0] sat_dec(
    input logic [31:0] v,
    input logic [31:0] n
  );
    if (v < n) return 32'd0;
    return v - n;
  endfunction

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0);
  endfunction

endpackage

// File: rtl/mole_hole.sv
// One playfield hole: EMPTY/UP/COOL state plus its tick timer.
// A hit always beats a same-cycle expiry, so no escape is reported then.
module mole_hole
  import mole_pkg::*;
#(
  parameter int UP_TICKS   = DEF_UP_TICKS,
  parameter int COOL_TICKS = DEF_COOL_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  input  logic spawn,
  input  logic hit,
  output logic up,
  output logic escape
);

  localparam int TMAX =
    (UP_TICKS > COOL_TICKS) ? UP_TICKS : COOL_TICKS;
  localparam int TW = $clog2(TMAX + 1);

  hole_state_t   state_q;
  logic [TW-1:0] timer_q;
  logic          expire;

  assign expire = tick && (timer_q <= TW'(1));
  assign up     = (state_q == UP);
  assign escape = up && expire && !hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      timer_q <= '0;
    end else if (clear) begin
      state_q <= EMPTY;
      timer_q <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (spawn) begin
            state_q <= UP;
            timer_q <= TW'(UP_TICKS);
          end
        end
        UP: begin
          if (hit || expire) begin
            state_q <= COOL;
            timer_q <= TW'(COOL_TICKS);
          end else if (tick) begin
            timer_q <= timer_q - TW'(1);
          end
        end
        COOL: begin
          if (expire) begin
            state_q <= EMPTY;
            timer_q <= '0;
          end else if (tick) begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= EMPTY;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mole_field_ctrl.sv
// Whack-a-mole playfield: tick divider, LFSR spawner, N holes, counters.
// Define MOLE_MISS_PENALTY_EN to make each miss also take a point off score.
module mole_field_ctrl
  import mole_pkg::*;
#(
  parameter int          N_HOLES     = DEF_N_HOLES,
  parameter int          TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int          UP_TICKS    = DEF_UP_TICKS,
  parameter int          COOL_TICKS  = DEF_COOL_TICKS,
  parameter int          SPAWN_TICKS = DEF_SPAWN_TICKS,
  parameter int          SCORE_W     = DEF_SCORE_W,
  parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       enable,
  input  logic                       whack_valid,
  input  logic [$clog2(N_HOLES)-1:0] whack_idx,
  output logic [N_HOLES-1:0]         mole_up,
  output logic                       hit_pulse,
  output logic                       miss_pulse,
  output logic                       escape_pulse,
  output logic [SCORE_W-1:0]         score,
  output logic [SCORE_W-1:0]         misses,
  output logic [SCORE_W-1:0]         escapes,
  output logic                       tick
);

  localparam int IDX_W = $clog2(N_HOLES);
  localparam int DIV_W =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SPN_W =
    (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam logic [31:0] SAT_MAX =
    (32'd1 << SCORE_W) - 32'd1;

  logic [15:0]        lfsr_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SPN_W-1:0]   spn_q, spn_d;
  logic [SCORE_W-1:0] score_q, misses_q, escapes_q;
  logic               hit_q, miss_q, esc_q;

  logic               tick_w, spawn_go, whack_go;
  logic               hit_w, miss_w;
  logic [7:0]         cand;
  logic [N_HOLES-1:0] up_vec, esc_vec, hit_vec, spawn_vec;
  logic [31:0]        esc_n, score_t, misses_t, escapes_t;

  assign tick_w   = enable && !clear && (div_q == '0);
  assign spawn_go = tick_w && (spn_q == '0);
  assign whack_go = enable && whack_valid && !clear;
  assign cand     = lfsr_q[7:0] % 8'(N_HOLES);

  for (genvar g = 0; g < N_HOLES; g++) begin : g_hole
    assign hit_vec[g] =
      whack_go && (whack_idx == IDX_W'(g)) && up_vec[g];
    assign spawn_vec[g] = spawn_go && (cand == 8'(g));

    mole_hole #(
      .UP_TICKS  (UP_TICKS),
      .COOL_TICKS(COOL_TICKS)
    ) u_hole (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .tick  (tick_w),
      .spawn (spawn_vec[g]),
      .hit   (hit_vec[g]),
      .up    (up_vec[g]),
      .escape(esc_vec[g])
    );
  end

  // Out-of-range indices never match a hole, so they land as misses.
  assign hit_w  = |hit_vec;
  assign miss_w = whack_go && !hit_w;

  always_comb begin
    div_d = div_q;
    if (enable) begin
      div_d = (div_q == '0) ? DIV_W'(TICK_CYCLES - 1)
                            : div_q - DIV_W'(1);
    end
    spn_d = spn_q;
    if (tick_w) begin
      spn_d = (spn_q == '0) ? SPN_W'(SPAWN_TICKS - 1)
                            : spn_q - SPN_W'(1);
    end
    esc_n = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      esc_n = esc_n + 32'(esc_vec[i]);
    end
    score_t = 32'(score_q);
    if (hit_w) begin
      score_t = sat_inc(score_t, 32'd1, SAT_MAX);
    end
`ifdef MOLE_MISS_PENALTY_EN
    else if (miss_w) begin
      score_t = sat_dec(score_t, 32'd1);
    end
`endif
    misses_t = 32'(misses_q);
    if (miss_w) begin
      misses_t = sat_inc(misses_t, 32'd1, SAT_MAX);
    end
    escapes_t = sat_inc(32'(escapes_q), esc_n, SAT_MAX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q    <= LFSR_SEED;
      div_q     <= DIV_W'(TICK_CYCLES - 1);
      spn_q     <= SPN_W'(SPAWN_TICKS - 1);
      score_q   <= '0;
      misses_q  <= '0;
      escapes_q <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      esc_q     <= 1'b0;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
      if (clear) begin
        div_q     <= DIV_W'(TICK_CYCLES - 1);
        spn_q     <= SPN_W'(SPAWN_TICKS - 1);
        score_q   <= '0;
        misses_q  <= '0;
        escapes_q <= '0;
        hit_q     <= 1'b0;
        miss_q    <= 1'b0;
        esc_q     <= 1'b0;
      end else begin
        div_q     <= div_d;
        spn_q     <= spn_d;
        score_q   <= score_t[SCORE_W-1:0];
        misses_q  <= misses_t[SCORE_W-1:0];
        escapes_q <= escapes_t[SCORE_W-1:0];
        hit_q     <= hit_w;
        miss_q    <= miss_w;
        esc_q     <= |esc_vec;
      end
    end
  end

  assign mole_up      = up_vec;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign escape_pulse = esc_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign escapes      = escapes_q;
  assign tick         = tick_w;

endmodule
